// File: rtl/act_pkg.sv
// Shared activation codes, FP16 constants and sequencer state encoding.
package act_pkg;

    localparam logic [2:0] ACT_NONE    = 3'd0;
    localparam logic [2:0] ACT_RELU    = 3'd1;
    localparam logic [2:0] ACT_RELU6   = 3'd2;
    localparam logic [2:0] ACT_LEAKY   = 3'd3;
    localparam logic [2:0] ACT_SIGMOID = 3'd4;
    localparam logic [2:0] ACT_TANH    = 3'd5;
    localparam logic [2:0] ACT_SWISH   = 3'd6;
    localparam logic [2:0] ACT_GELU    = 3'd7;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_SIX  = 16'h4600;
    localparam logic [15:0] FP16_HALF = 16'h3800;

    typedef enum logic [2:0] {IDLE, RD, CAPT, OUT, DONE} state_t;

endpackage

// File: rtl/activation_functions.sv
// One activation lane: combinational function of i_data, registered when i_en is high.
// Latency 1 cycle; holds its output indefinitely while i_en is low (no backpressure of its own).
module activation_functions
    import act_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter bit IS_FLOATING_POINT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [2:0]            i_act_type,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_neg;

    assign w_neg = i_data[DATA_WIDTH-1];

    generate
        if (IS_FLOATING_POINT) begin : g_fp
            // Smooth functions are coarse piecewise stand-ins; sigmoid/tanh saturate at |x|>=1.
            logic       w_ge_six;
            logic       w_mag_ge_one;
            logic [4:0] w_exp;

            assign w_exp        = i_data[14:10];
            assign w_ge_six     = !w_neg && (i_data[14:0] >= FP16_SIX[14:0]);
            assign w_mag_ge_one = (i_data[14:0] >= FP16_ONE[14:0]);

            always_comb begin
                w_result = i_data;
                case (i_act_type)
                    ACT_RELU, ACT_SWISH, ACT_GELU: if (w_neg) w_result = FP16_ZERO;
                    ACT_RELU6: begin
                        if (w_neg)         w_result = FP16_ZERO;
                        else if (w_ge_six) w_result = FP16_SIX;
                    end
                    ACT_LEAKY: if (w_neg) w_result = (w_exp > 5'd3) ? {1'b1, w_exp - 5'd3, i_data[9:0]} : 16'h8000;
                    ACT_SIGMOID: w_result = !w_mag_ge_one ? FP16_HALF : (w_neg ? FP16_ZERO : FP16_ONE);
                    ACT_TANH: if (w_mag_ge_one) w_result = w_neg ? (FP16_ONE | 16'h8000) : FP16_ONE;
                    default: w_result = i_data;
                endcase
            end
        end else begin : g_int
            localparam logic [DATA_WIDTH-1:0] C_ONE = DATA_WIDTH'(1);
            localparam logic [DATA_WIDTH-1:0] C_SIX = DATA_WIDTH'(6);
            logic w_zero;

            assign w_zero = (i_data == '0);

            always_comb begin
                w_result = i_data;
                case (i_act_type)
                    ACT_RELU, ACT_SWISH, ACT_GELU: if (w_neg) w_result = '0;
                    ACT_RELU6: begin
                        if (w_neg)                w_result = '0;
                        else if (i_data >= C_SIX) w_result = C_SIX;
                    end
                    ACT_LEAKY:   if (w_neg) w_result = DATA_WIDTH'($signed(i_data) >>> 3);
                    ACT_SIGMOID: w_result = (w_neg || w_zero) ? '0 : C_ONE;
                    ACT_TANH:    w_result = w_neg ? {DATA_WIDTH{1'b1}} : (w_zero ? '0 : C_ONE);
                    default:     w_result = i_data;
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_data <= '0;
        else if (i_en) r_data <= w_result;
    end

    assign o_data = r_data;

endmodule

// File: rtl/activation_sequencer.sv
// Row-serial activation job controller: RD -> CAPT -> OUT per row, first out_valid 3 cycles after accept.
// OUT holds all outputs stable while out_ready is low; one row per 3 cycles at best.
module activation_sequencer
    import act_pkg::*;
#(
    parameter int SIZE              = 8,
    parameter int DATA_WIDTH        = 16,
    parameter bit IS_FLOATING_POINT = 1'b1,
    parameter int ADDR_WIDTH        = 4,
    parameter int MAX_ROWS          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [2:0]                   cfg_act_type,
    input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic [ADDR_WIDTH:0]          cfg_num_rows,
    input  logic                         abort,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [SIZE*DATA_WIDTH-1:0]   rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH:0]          out_row,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         aborted
);

    localparam int              RW          = ADDR_WIDTH + 1;
    localparam logic [RW-1:0]   LP_MAX_ROWS = RW'(MAX_ROWS);

    state_t                   r_state;
    logic [2:0]               r_act;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [RW-1:0]            r_num_rows;
    logic [RW-1:0]            r_row;
    logic                     r_cfg_ready, r_rd_en, r_out_valid, r_out_last;
    logic                     r_busy, r_done, r_err, r_aborted;
    logic [ADDR_WIDTH-1:0]    r_rd_addr;
    logic [RW-1:0]            r_out_row;

    logic                     w_lane_en;
    logic                     w_illegal;
    logic                     w_is_last;
    logic [RW-1:0]            w_next_row;
    logic [SIZE*DATA_WIDTH-1:0] w_lane_out;

    assign w_lane_en  = (r_state == CAPT);
    assign w_illegal  = (cfg_num_rows == '0) || (cfg_num_rows > LP_MAX_ROWS);
    assign w_is_last  = (r_row == r_num_rows - RW'(1));
    assign w_next_row = r_row + RW'(1);

    generate
        for (genvar g = 0; g < SIZE; g++) begin : g_lane
            activation_functions #(
                .DATA_WIDTH        (DATA_WIDTH),
                .IS_FLOATING_POINT (IS_FLOATING_POINT)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_en       (w_lane_en),
                .i_act_type (r_act),
                .i_data     (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_data     (w_lane_out[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_act       <= '0;
            r_base      <= '0;
            r_num_rows  <= '0;
            r_row       <= '0;
            r_cfg_ready <= 1'b1;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (cfg_valid) begin
                    r_act       <= cfg_act_type;
                    r_base      <= cfg_base_addr;
                    r_num_rows  <= cfg_num_rows;
                    r_row       <= '0;
                    r_cfg_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    if (w_illegal) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state   <= RD;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= cfg_base_addr;
                    end
                end
                RD: begin
                    r_rd_en <= 1'b0;
                    if (abort) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= CAPT;
                    end
                end
                CAPT: begin
                    if (abort) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                        r_out_row   <= r_row;
                        r_out_last  <= w_is_last;
                    end
                end
                OUT: begin
                    // A row accepted in the abort cycle still counts as transferred.
                    if (out_ready) r_row <= w_next_row;
                    if (abort || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                    if (abort) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= RD;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_base + w_next_row[ADDR_WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_aborted   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign out_data  = w_lane_out;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign aborted   = r_aborted;

endmodule
